channel_ctrl: RTL and testbench

//   Control-side counterpart of the per-channel on-screen display. Turns raw front-panel

---
 rtl/channel_ctrl.sv | 148 ++++++++++++++
 tb/tb_channel_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/channel_ctrl.sv
// Per-channel front-panel control: debounced buttons drive scale code, coupling-mode glyph and trace offset.
// Outputs update DEBOUNCE_CYCLES+3 cycles after a raw button edge; changed pulses in that same cycle.
module channel_ctrl #(
  parameter int         DEBOUNCE_CYCLES = 1_000_000,
  parameter int         REPEAT_DELAY    = 50_000_000,
  parameter int         REPEAT_PERIOD   = 5_000_000,
  parameter logic [3:0] SCALE_INIT      = 4'd4,
  parameter logic [3:0] SCALE_MAX       = 4'd9,
  parameter logic [9:0] OFFSET_INIT     = 10'd240,
  parameter logic [9:0] OFFSET_MIN      = 10'd16,
  parameter logic [9:0] OFFSET_MAX      = 10'd464,
  parameter logic [9:0] OFFSET_STEP     = 10'd4,
  parameter logic [4:0] MODE0           = 5'd10,
  parameter logic [4:0] MODE1           = 5'd11,
  parameter logic [4:0] MODE2           = 5'd12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sel,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_scale_up,
  input  logic       btn_scale_dn,
  input  logic       btn_mode,
  output logic [3:0] scale_out,
  output logic [4:0] mode_out,
  output logic [9:0] offset_y_move,
  output logic       changed
);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_W = $clog2(RMAX + 1);

  typedef enum logic [1:0] {IDLE, HOLD, RPT} state_t;

  logic [4:0]            sync1_q, sync1_d, sync2_q, sync2_d;
  logic [4:0]            stable_q, stable_d, stable_prev_q, stable_prev_d, press;
  logic [4:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
  state_t                state_q, state_d;
  logic [RP_W-1:0]       rpt_cnt_q, rpt_cnt_d;
  logic                  hold_one, press_one, step;
  logic [3:0]            scale_q, scale_d;
  logic [4:0]            mode_q, mode_d;
  logic [9:0]            offset_q, offset_d;
  logic [10:0]           off_dn;
  logic                  changed_q, changed_d;

  // bit order: 0 up, 1 down, 2 scale up, 3 scale down, 4 mode
  assign sync1_d       = {btn_mode, btn_scale_dn, btn_scale_up, btn_down, btn_up};
  assign sync2_d       = sync1_q;
  assign stable_prev_d = stable_q;
  assign press         = stable_q & ~stable_prev_q & {5{sel}};

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      db_cnt_d[i] = '0;
      stable_d[i] = stable_q[i];
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) stable_d[i] = sync2_q[i];
        else db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  // A held offset button only counts while it is the only one held and the channel is selected.
  assign hold_one  = sel & (stable_q[0] ^ stable_q[1]);
  assign press_one = hold_one & (press[0] | press[1]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (press_one) state_d = HOLD;
      HOLD:    if (!hold_one) state_d = IDLE;
               else if (rpt_cnt_q == RP_W'(REPEAT_DELAY - 1)) state_d = RPT;
      RPT:     if (!hold_one) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    step      = 1'b0;
    rpt_cnt_d = '0;
    case (state_q)
      IDLE: step = press_one;
      HOLD: if (hold_one) begin
              if (rpt_cnt_q == RP_W'(REPEAT_DELAY - 1)) step = 1'b1;
              else rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
      RPT:  if (hold_one) begin
              if (rpt_cnt_q == RP_W'(REPEAT_PERIOD - 1)) step = 1'b1;
              else rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
      default: ;
    endcase
  end

  assign off_dn = {1'b0, offset_q} + {1'b0, OFFSET_STEP};

  always_comb begin
    offset_d = offset_q;
    if (step) begin
      if (stable_q[1]) offset_d = (off_dn > {1'b0, OFFSET_MAX}) ? OFFSET_MAX : off_dn[9:0];
      else offset_d = (offset_q < OFFSET_MIN + OFFSET_STEP) ? OFFSET_MIN : offset_q - OFFSET_STEP;
    end

    scale_d = scale_q;
    if (press[2] && !press[3] && scale_q < SCALE_MAX) scale_d = scale_q + 4'd1;
    else if (press[3] && !press[2] && scale_q != 4'd0) scale_d = scale_q - 4'd1;

    mode_d = mode_q;
    if (press[4]) mode_d = (mode_q == MODE0) ? MODE1 : (mode_q == MODE1) ? MODE2 : MODE0;

    changed_d = (scale_d != scale_q) | (mode_d != mode_q) | (offset_d != offset_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      db_cnt_q      <= '0;
      state_q       <= IDLE;
      rpt_cnt_q     <= '0;
      scale_q       <= SCALE_INIT;
      mode_q        <= MODE0;
      offset_q      <= OFFSET_INIT;
      changed_q     <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      db_cnt_q      <= db_cnt_d;
      state_q       <= state_d;
      rpt_cnt_q     <= rpt_cnt_d;
      scale_q       <= scale_d;
      mode_q        <= mode_d;
      offset_q      <= offset_d;
      changed_q     <= changed_d;
    end
  end

  assign scale_out     = scale_q;
  assign mode_out      = mode_q;
  assign offset_y_move = offset_q;
  assign changed       = changed_q;
endmodule

// File: tb/tb_channel_ctrl.sv
// Bench for channel_ctrl: expected output updates (edge, scale, mode, offset) are queued when
// buttons are driven and popped whenever the DUT pulses changed.
module tb_channel_ctrl;
  localparam int DEB  = 4;
  localparam int RDLY = 8;
  localparam int RPER = 3;

  typedef struct {
    int edge_no;
    int scale;
    int mode;
    int off;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel;
  logic [4:0] btn;
  logic [3:0] scale_out;
  logic [4:0] mode_out;
  logic [9:0] offset_y_move;
  logic       changed;

  int   cyc = 0;
  int   t0  = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   m_scale, m_mode, m_off;
  exp_t sb[$];
  exp_t mon_e;

  channel_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RDLY),
    .REPEAT_PERIOD  (RPER)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sel          (sel),
    .btn_up       (btn[0]),
    .btn_down     (btn[1]),
    .btn_scale_up (btn[2]),
    .btn_scale_dn (btn[3]),
    .btn_mode     (btn[4]),
    .scale_out    (scale_out),
    .mode_out     (mode_out),
    .offset_y_move(offset_y_move),
    .changed      (changed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int obs, input int exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && changed === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("unexpected_changed_at_cycle", cyc, -1);
      end else begin
        mon_e = sb.pop_front();
        check_val("changed_edge", cyc, mon_e.edge_no);
        check_val("scale_out", int'(scale_out), mon_e.scale);
        check_val("mode_out", int'(mode_out), mon_e.mode);
        check_val("offset_y_move", int'(offset_y_move), mon_e.off);
      end
    end
  end

  task automatic model_reset();
    m_scale = 4;
    m_mode  = 10;
    m_off   = 240;
  endtask

  task automatic push_rel(input int rel);
    sb.push_back('{t0 + rel, m_scale, m_mode, m_off});
  endtask

  // Offset steps land at edge DEB+3, then DEB+3+RDLY, then every RPER while the button stays stable.
  task automatic push_offset_steps(input bit down, input int last_edge);
    int nv;
    for (int t = DEB + 3; t <= last_edge; t = (t == DEB + 3) ? t + RDLY : t + RPER) begin
      nv = down ? m_off + 4 : m_off - 4;
      if (nv > 464) nv = 464;
      if (nv < 16)  nv = 16;
      if (nv != m_off) begin
        m_off = nv;
        push_rel(t);
      end
    end
  endtask

  task automatic pulse(input int idx, input int hold_n, input int settle_n);
    btn[idx] = 1'b1;
    repeat (hold_n) @(negedge clk);
    btn[idx] = 1'b0;
    repeat (settle_n) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    check_val({tag, "_scale"}, int'(scale_out), m_scale);
    check_val({tag, "_mode"}, int'(mode_out), m_mode);
    check_val({tag, "_offset"}, int'(offset_y_move), m_off);
    check_val({tag, "_pending"}, sb.size(), 0);
  endtask

  task automatic next_mode();
    m_mode = (m_mode == 10) ? 11 : (m_mode == 11) ? 12 : 10;
  endtask

  initial begin
    rst_n = 1'b0;
    sel   = 1'b1;
    btn   = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_state("reset");
    check_val("reset_changed", int'(changed), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // scale up held 20 cycles: single step, no repeat
    t0 = cyc; m_scale = 5; push_rel(DEB + 3);
    pulse(2, 20, 20);
    check_state("scale_hold");

    // mode glitch shorter than the debounce window, then three clean presses
    pulse(4, 2, 15);
    check_state("mode_glitch");
    for (int i = 0; i < 3; i++) begin
      t0 = cyc; next_mode(); push_rel(DEB + 3);
      pulse(4, 8, 15);
    end
    check_state("mode_cycle");

    // scale down saturates at 0
    for (int i = 0; i < 7; i++) begin
      t0 = cyc;
      if (m_scale > 0) begin m_scale--; push_rel(DEB + 3); end
      pulse(3, 8, 12);
    end
    check_state("scale_floor");

    // both scale buttons together: no change
    btn[2] = 1'b1; btn[3] = 1'b1;
    repeat (10) @(negedge clk);
    btn = '0;
    repeat (12) @(negedge clk);
    check_state("scale_both");

    // offset down held 30 cycles with auto-repeat
    t0 = cyc; push_offset_steps(1'b1, 30 + DEB + 2);
    pulse(1, 30, 20);
    check_state("offset_repeat");

    // offset up held long: clamps at the lower limit with no further changed pulses
    t0 = cyc; push_offset_steps(1'b0, 260 + DEB + 2);
    pulse(0, 260, 20);
    check_state("offset_clamp");
    check_val("offset_at_min", int'(offset_y_move), 16);

    // deselected: every button ignored
    sel = 1'b0;
    for (int i = 0; i < 5; i++) pulse(i, 20, 12);
    check_state("sel_off");
    sel = 1'b1;
    repeat (4) @(negedge clk);

    // up and down held together: no step
    btn[0] = 1'b1; btn[1] = 1'b1;
    repeat (30) @(negedge clk);
    btn = '0;
    repeat (15) @(negedge clk);
    check_state("up_down_both");

    // reset while repeating; held button must re-debounce afterwards
    t0 = cyc; push_offset_steps(1'b1, DEB + 3 + RDLY + RPER);
    btn[1] = 1'b1;
    repeat (DEB + 3 + RDLY + RPER + 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state("mid_reset");
    check_val("mid_reset_changed", int'(changed), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    t0 = cyc; push_offset_steps(1'b1, 10 + DEB + 2);
    repeat (10) @(negedge clk);
    btn[1] = 1'b0;
    repeat (20) @(negedge clk);
    check_state("post_reset_press");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
